// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between
// instruction fetch (0), data access (1) and the loader/debug port (2).
// Round-robin arbitration with a combinational grant, command mux onto the
// memory port, fixed-latency read-data return and sticky starvation flags.
// Optional build macro: MEM_ARB_LOCK_EN adds a 3-bit lock input that lets
// the winner hold the port for a burst of up to 8 consecutive grants.
module mem_port_arbiter #(
    parameter int N        = 8,
    parameter int NREQ     = 3,
    parameter int RD_LAT   = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*N-1:0] addr,
    input  logic [NREQ*N-1:0] wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    input  logic              starve_clr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [N-1:0]      rdata,
    output logic [NREQ-1:0]   starve,
    output logic              mem_en,
    output logic              mem_we,
    output logic [N-1:0]      mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam int IW = 2;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IW-1:0]            ptr_q, ptr_d;
    logic [NREQ-1:0]          elig_s;
    logic [NREQ-1:0]          win_onehot_s;
    logic [NREQ-1:0]          gnt_s;
    logic [IW-1:0]            win_idx_s;
    logic [IW-1:0]            cand_s;
    logic                     win_found_s;
    logic                     grant_any_s;
    logic                     lock_hold_s;

    logic [RD_LAT-1:0]           rsp_vld_q, rsp_vld_d;
    logic [RD_LAT-1:0][IW-1:0]   rsp_id_q, rsp_id_d;

    logic [NREQ-1:0][CW-1:0]  wcnt_q, wcnt_d;
    logic [NREQ-1:0]          starve_q, starve_d;

`ifdef MEM_ARB_LOCK_EN
    logic                     lock_own_q, lock_own_d;
    logic [IW-1:0]            owner_q, owner_d;
    logic [3:0]               burst_q, burst_d;

    // Restrict eligibility to the lock owner while a locked burst is active.
    always_comb begin
        if (lock_own_q) begin
            elig_s = req & (ONE_HOT0 << owner_q);
        end else begin
            elig_s = req;
        end
    end

    // Lock ownership: take on a locked grant, drop on unlocked grant,
    // owner idle, or after the eighth consecutive locked grant.
    always_comb begin
        lock_own_d = lock_own_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        if (!lock_own_q) begin
            if (grant_any_s && lock[win_idx_s]) begin
                lock_own_d = 1'b1;
                owner_d    = win_idx_s;
                burst_d    = 4'd1;
            end else begin
                burst_d    = 4'd0;
            end
        end else begin
            if (!req[owner_q]) begin
                lock_own_d = 1'b0;
                burst_d    = 4'd0;
            end else if (gnt_s[owner_q]) begin
                if (!lock[owner_q] || (burst_q == 4'd7)) begin
                    lock_own_d = 1'b0;
                    burst_d    = 4'd0;
                end else begin
                    burst_d    = burst_q + 4'd1;
                end
            end else begin
                burst_d    = burst_q;
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_own_q <= 1'b0;
            owner_q    <= 2'd0;
            burst_q    <= 4'd0;
        end else begin
            lock_own_q <= lock_own_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
        end
    end

    assign lock_hold_s = lock_own_q;
`else
    assign elig_s      = req;
    assign lock_hold_s = 1'b0;
`endif

    // Round-robin search starting one past the last winner, wrapping at NREQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (cand_s == 2'd2) begin
                cand_s = 2'd0;
            end else begin
                cand_s = cand_s + 2'd1;
            end
            if (!win_found_s && elig_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        if (win_found_s) begin
            win_onehot_s = ONE_HOT0 << win_idx_s;
        end else begin
            win_onehot_s = {NREQ{1'b0}};
        end
    end

    assign gnt_s       = win_onehot_s;
    assign gnt         = gnt_s;
    assign grant_any_s = |gnt_s;

    // Drive the winner's command onto the memory port; idle bus is all-zero.
    always_comb begin
        mem_en    = grant_any_s;
        mem_we    = 1'b0;
        mem_addr  = {N{1'b0}};
        mem_wdata = {N{1'b0}};
        if (grant_any_s) begin
            mem_we    = we[win_idx_s];
            mem_addr  = addr[win_idx_s*N +: N];
            mem_wdata = wdata[win_idx_s*N +: N];
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Pointer follows the winner except while a locked burst holds the port.
    always_comb begin
        if (grant_any_s && !lock_hold_s) begin
            ptr_d = win_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Read-response shift pipeline: granted reads enter with their id.
    always_comb begin
        rsp_vld_d[0] = grant_any_s & ~we[win_idx_s];
        rsp_id_d[0]  = win_idx_s;
        for (int s = 1; s < RD_LAT; s++) begin
            rsp_vld_d[s] = rsp_vld_q[s-1];
            rsp_id_d[s]  = rsp_id_q[s-1];
        end
    end

    // Present read data to the requester whose response reaches the end.
    always_comb begin
        rvalid = {NREQ{1'b0}};
        rdata  = {N{1'b0}};
        if (rsp_vld_q[RD_LAT-1]) begin
            rvalid = ONE_HOT0 << rsp_id_q[RD_LAT-1];
            rdata  = mem_rdata;
        end else begin
            rdata  = {N{1'b0}};
        end
    end

    // Wait counters saturate at WAIT_MAX; starve is sticky; clear wins.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            if (starve_clr) begin
                wcnt_d[i]   = {CW{1'b0}};
                starve_d[i] = 1'b0;
            end else begin
                if (gnt_s[i]) begin
                    wcnt_d[i] = {CW{1'b0}};
                end else if (req[i] && (wcnt_q[i] < CW'(WAIT_MAX))) begin
                    wcnt_d[i] = wcnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    wcnt_d[i] = wcnt_q[i];
                end
                starve_d[i] = starve_q[i] | (wcnt_d[i] == CW'(WAIT_MAX));
            end
        end
    end

    assign starve = starve_q;

    // State registers; reset drops any in-flight read responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= 2'd2;
            rsp_vld_q <= {RD_LAT{1'b0}};
            rsp_id_q  <= {(RD_LAT*IW){1'b0}};
            wcnt_q    <= {(NREQ*CW){1'b0}};
            starve_q  <= {NREQ{1'b0}};
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            wcnt_q    <= wcnt_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester transaction lists
// drive the ports, a reference arbiter/memory model predicts each grant and
// read response, and a monitor pops predicted responses against rvalid/rdata.
module tb_mem_port_arbiter;
    localparam int N        = 8;
    localparam int NREQ     = 3;
    localparam int RD_LAT   = 2;
    localparam int WAIT_MAX = 15;
    localparam int CAP      = 512;

    typedef struct packed { logic w; logic [7:0] a; logic [7:0] d; } txn_t;
    typedef struct packed { logic [1:0] id; logic [7:0] d; int due; } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, we;
    logic [23:0] addr, wdata;
    logic        starve_clr;
    logic [2:0]  gnt, rvalid, starve;
    logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
`ifdef MEM_ARB_LOCK_EN
    logic [2:0]  lock = 3'b000;
`endif

    txn_t tlist [NREQ][CAP];
    int   thead [NREQ];
    int   ttail [NREQ];
    rsp_t rsp_q [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mptr = 2;
    logic chk_en;
    logic rnd_gap;
    logic [2:0] gnt_seen = 3'b000;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] mpipe [RD_LAT];
    logic       env_init = 1'b0;

    mem_port_arbiter #(.N(N), .NREQ(NREQ), .RD_LAT(RD_LAT), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_ARB_LOCK_EN
        .lock(lock),
`endif
        .starve_clr(starve_clr), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .starve(starve), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 37 + 92);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory macro model: writes land at the edge, reads return RD_LAT later.
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (mem_en && mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        mpipe[0] <= (env_init && mem_en && !mem_we) ? env_mem[mem_addr] : 8'($urandom);
        for (int s = 1; s < RD_LAT; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mem_rdata = mpipe[RD_LAT-1];

    // Reference arbiter: predict winner and bus, update reference memory, push reads.
    initial begin
        int w;
        int c;
        logic [7:0] a;
        logic [7:0] d;
        rsp_t r;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            gnt_seen = gnt;
            if (reset) begin
                mptr = 2;
            end else if (chk_en) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (mptr + k) % NREQ;
                    if (w < 0 && req[c]) w = c;
                end
                chk("gnt", gnt, (w < 0) ? 0 : (1 << w));
                chk("mem_en", mem_en, (w >= 0) ? 1 : 0);
                if (w >= 0) begin
                    a = addr[w*8 +: 8];
                    d = wdata[w*8 +: 8];
                    chk("mem_we", mem_we, we[w]);
                    chk("mem_addr", mem_addr, a);
                    if (we[w]) begin
                        chk("mem_wdata", mem_wdata, d);
                        ref_mem[a] = d;
                    end else begin
                        r.id  = 2'(w);
                        r.d   = ref_mem[a];
                        r.due = cyc + RD_LAT;
                        rsp_q.push_back(r);
                    end
                    mptr = w;
                end else begin
                    chk("idle_bus", {mem_we, mem_addr, mem_wdata}, 0);
                end
            end
        end
    end

    // Response monitor: rvalid only when a predicted read is due.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_q.delete();
            end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                e = rsp_q.pop_front();
                chk("rvalid", rvalid, 3'b001 << e.id);
                chk("rdata", rdata, e.d);
            end else begin
                chk("rvalid_idle", rvalid, 0);
            end
        end
    end

    task automatic push(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
        tlist[r][ttail[r]] = '{w: w, a: a, d: d};
        ttail[r]++;
    endtask

    task automatic step();
        txn_t t;
        @(posedge clk);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (req[r] && gnt_seen[r]) begin
                thead[r]++;
                req[r] = 1'b0;
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (!req[r] && thead[r] != ttail[r] && (!rnd_gap || $urandom_range(0, 2) != 0)) begin
                t = tlist[r][thead[r]];
                req[r] = 1'b1;
                we[r] = t.w;
                addr[r*8 +: 8] = t.a;
                wdata[r*8 +: 8] = t.d;
            end
        end
    endtask

    function automatic logic busy();
        logic b;
        b = (|req) || (rsp_q.size() != 0);
        for (int r = 0; r < NREQ; r++) if (thead[r] != ttail[r]) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            step();
            n++;
        end
        chk("drain_done", busy(), 0);
    endtask

    initial begin
        reset = 1'b1; req = 3'b000; we = 3'b000; addr = 24'h0; wdata = 24'h0;
        starve_clr = 1'b0; chk_en = 1'b1; rnd_gap = 1'b0;
        for (int r = 0; r < NREQ; r++) begin thead[r] = 0; ttail[r] = 0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_starve", starve, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_bus", {mem_en, mem_we, mem_addr, mem_wdata}, 0);

        // All three read at once: grants 0,1,2 in order.
        push(0, 1'b0, 8'h10, 8'h00);
        push(1, 1'b0, 8'h20, 8'h00);
        push(2, 1'b0, 8'h30, 8'h00);
        drain(100);

        // Requester 1 streaming reads alone.
        for (int i = 0; i < 6; i++) push(1, 1'b0, 8'($urandom), 8'h00);
        drain(100);

        // Requester 2 write then read back.
        push(2, 1'b1, 8'h05, 8'hA5);
        push(2, 1'b0, 8'h05, 8'h00);
        drain(100);

        // Random traffic over a small address window for read-after-write hits.
        rnd_gap = 1'b1;
        for (int i = 0; i < 60; i++)
            for (int r = 0; r < NREQ; r++)
                push(r, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        drain(3000);
        rnd_gap = 1'b0;
        @(negedge clk);
        chk("starve_none", starve, 0);

        // Reset with two reads in flight: their responses must vanish.
        push(1, 1'b0, 8'h21, 8'h00);
        push(1, 1'b0, 8'h22, 8'h00);
        step();
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        req = 3'b000;
        for (int r = 0; r < NREQ; r++) thead[r] = ttail[r];
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        push(0, 1'b0, 8'h31, 8'h00);
        push(1, 1'b0, 8'h32, 8'h00);
        push(2, 1'b0, 8'h33, 8'h00);
        drain(100);

        // Starvation: hold req0 with its grant suppressed for WAIT_MAX cycles.
        chk_en = 1'b0;
        force dut.gnt_s = 3'b000;
        push(0, 1'b0, 8'h40, 8'h00);
        step();
        for (int i = 1; i <= WAIT_MAX; i++) begin
            step();
            @(negedge clk);
            chk("starve_ramp", starve[0], (i >= WAIT_MAX) ? 1'b1 : 1'b0);
        end
        step();
        release dut.gnt_s;
        chk_en = 1'b1;
        drain(50);
        @(negedge clk);
        chk("starve_sticky", starve, 3'b001);
        @(posedge clk);
        #1 starve_clr = 1'b1;
        @(posedge clk);
        #1 starve_clr = 1'b0;
        @(negedge clk);
        chk("starve_clr", starve, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous data memory between three requesters: instruction fetch (req 0), data access (req 1) and the program loader/debug port (req 2).
- Round-robin arbitration with a combinational grant.
- Muxes the winner's command onto the memory port.
- Returns read data to the winner after a fixed, parameterised latency.
- Sits between the 8-bit multicycle core plus loader and the memory macro.

Parameters:
- N, 8, data and address width.
- NREQ, 3, number of requesters (fixed at 3 for this revision).
- RD_LAT, 1, memory read latency in cycles; legal range 1..4.
- WAIT_MAX, 15, cycles a pending request may wait before its starve flag sets.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  3  per-requester request; held high until gnt is seen.
- we  in  3  per-requester write enable; valid while req is high.
- addr  in  3*N  per-requester address; requester i uses slice [i*N +: N].
- wdata  in  3*N  per-requester write data, same slicing as addr.
- gnt  out  3  one-hot grant; combinational, same cycle as the winning req.
- rvalid  out  3  one-hot read-data-valid.
- rdata  out  N  read data; valid when any rvalid bit is high.
- starve  out  3  sticky per-requester starvation flag.
- starve_clr  in  1  clears all starve flags and wait counters.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  N  memory address.
- mem_wdata  out  N  memory write data.
- mem_rdata  in  N  memory read data, RD_LAT cycles after an access with mem_en=1 and mem_we=0.

Behaviour:
Reset:
- ptr=2, so requester 0 wins first.
- rsp pipeline cleared; rvalid=0.
- starve=0; wait counters=0.
- Combinational outputs with req=0: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Reset asserted mid-operation:
- All in-flight read responses are dropped; no rvalid is issued for them.
- The memory is not notified.

Arbitration, every cycle:
- Search req starting at index (ptr+1) mod 3 and wrapping; the first set bit wins.
- gnt is one-hot for the winner, all-zero if no req.
- mem_en=|gnt; mem_we, mem_addr and mem_wdata are muxed from the winner.
- When gnt is non-zero, ptr is loaded with the winner's index at the edge; otherwise ptr holds.
- Throughput is one access per cycle. A requester may win on consecutive cycles only when no other req is high.
- Handshake: the transfer completes at the edge where req and gnt are both high. The requester may change addr/we/wdata or drop req after that edge. Inputs must be stable while req is high and gnt is low.

Read response:
- A granted read (we=0) pushes {valid=1, id} into an RD_LAT-deep shift pipeline.
- At the pipeline output, rvalid[id]=1 and rdata=mem_rdata, valid for exactly one cycle.
- Granted writes push valid=0; they produce no response.
- Responses never reorder.

Starvation:
- For each i, wait_cnt[i] increments each cycle req[i]=1 and gnt[i]=0; it clears on gnt[i].
- When wait_cnt[i] reaches WAIT_MAX, starve[i] sets and stays set until starve_clr or reset.
- Counters saturate at WAIT_MAX.
- starve_clr in the same cycle as a set condition: clear wins.
- With round-robin and no lock, starve can only set if a requester holds req for more than 2 cycles without gnt. That is a protocol error indicator.

Optional Feature:
Macro: MEM_ARB_LOCK_EN.

When defined:
- Adds input port lock (3 bits).
- If the winner's lock bit is set at the grant edge, lock_own=1 and owner=winner.
- While lock_own=1, only the owner is eligible and ptr is not updated.
- lock_own clears at the first edge where the owner is granted with lock low, or the owner's req is low.
- A burst counter forces release after 8 consecutive locked grants, even if lock stays high. Arbitration then resumes from ptr = owner.
- Non-owner waiting cycles still count toward starve.

When not defined:
- No lock port and no lock state.
- Pure round-robin.

Test Plan:
- Reset, then req=3'b111, all reads, addr0=8'h10, addr1=8'h20, addr2=8'h30, each requester dropping req after its grant. Required:
  - Grants 0, 1, 2 on consecutive cycles with mem_addr 10, 20, 30.
  - rvalid 001, 010, 100, RD_LAT cycles after each grant, carrying the matching mem_rdata.
- req1 held high with a stream of reads, other reqs low -> gnt=010 every cycle and one rvalid[1] per read.
- Requester 2 writes addr=8'h05, wdata=8'hA5, then reads 8'h05 -> mem_we=1 only on the write cycle; rvalid[2] with rdata=8'hA5; no rvalid for the write.
- Reset asserted while two reads are in flight (RD_LAT=2) -> rvalid stays 0 after reset; the first post-reset grant goes to requester 0.
- Bench forces req0 high with gnt0 suppressed for 15 cycles (WAIT_MAX=15) -> starve[0]=1 on cycle 15; it clears on starve_clr.
- MEM_ARB_LOCK_EN: requester 1 locks with req0 pending -> gnt stays 010 for 8 grants, then gnt=001 on the next cycle.
